// File: rtl/coreabc_fifo_pkg.sv
// coreabc_fifo_pkg: shared defaults and output-buffer state encoding for the COREABC RAM FIFO
package coreabc_fifo_pkg;
  localparam int FIFO_ADDR_W = 8;
  localparam int FIFO_DATA_W = 8;
  typedef enum logic [1:0] {OB_EMPTY = 2'd0, OB_ONE = 2'd1, OB_TWO = 2'd2} ob_state_e;
endpackage

// File: rtl/coreabc_fifo_outbuf.sv
// coreabc_fifo_outbuf: 2-entry output buffer (head + skid) with a bypass for data arriving from the RAM
module coreabc_fifo_outbuf
  import coreabc_fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              inflight,
  input  logic [DATA_W-1:0] ram_rd,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        ob_cnt
);
  ob_state_e state, state_n;
  logic [DATA_W-1:0] head, skid, head_n, e0, e1;
  logic [1:0] nn;
  logic pop;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OB_EMPTY;
      head  <= '0;
      skid  <= '0;
    end else begin
      state <= state_n;
      head  <= head_n;
      skid  <= e1;
    end
  end
  // entries in order: head/bypass (e0), then skid/arriving (e1); head keeps the last shown byte when emptied
  always_comb begin
    e0       = (state == OB_EMPTY && inflight) ? ram_rd : head;
    e1       = (state == OB_TWO) ? skid : ram_rd;
    rd_valid = state != OB_EMPTY || inflight;
    rd_data  = e0;
    pop      = rd_valid && rd_ready && !flush;
    nn       = 2'(state) + 2'(inflight) - 2'(pop);
    state_n  = flush ? OB_EMPTY : ob_state_e'(nn);
    head_n   = flush ? head : (pop && nn != 2'd0) ? e1 : e0;
    ob_cnt   = 2'(state);
  end
endmodule

// File: rtl/coreabc_ram_fifo_ctrl.sv
// coreabc_ram_fifo_ctrl: circular-buffer FIFO controller in front of the COREABC 256x8 RAM.
// Optional synchronous FLUSH port enabled by COREABC_FIFO_FLUSH_EN.
module coreabc_ram_fifo_ctrl
  import coreabc_fifo_pkg::*;
#(
  parameter int ADDR_W = FIFO_ADDR_W,
  parameter int DATA_W = FIFO_DATA_W
) (
  input  logic              PCLK,
  input  logic              NSYSRESET,
`ifdef COREABC_FIFO_FLUSH_EN
  input  logic              FLUSH,
`endif
  input  logic              WR_VALID,
  output logic              WR_READY,
  input  logic [DATA_W-1:0] WR_DATA,
  output logic              RD_VALID,
  input  logic              RD_READY,
  output logic [DATA_W-1:0] RD_DATA,
  output logic [ADDR_W:0]   COUNT,
  output logic              RAM_WEN,
  output logic [ADDR_W-1:0] RAM_WADDR,
  output logic [DATA_W-1:0] RAM_WD,
  output logic              RAM_REN,
  output logic [ADDR_W-1:0] RAM_RADDR,
  input  logic [DATA_W-1:0] RAM_RD
);
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0] cnt, ram_cnt;
  logic [2:0] occ;
  logic [1:0] ob_cnt;
  logic inflight, flush, push, pop, ren;
`ifdef COREABC_FIFO_FLUSH_EN
  assign flush = FLUSH;
`else
  assign flush = 1'b0;
`endif
  // cnt never exceeds DEPTH, so its MSB alone marks full
  assign WR_READY  = !cnt[ADDR_W] && !flush;
  assign push      = WR_VALID && WR_READY;
  assign pop       = RD_VALID && RD_READY && !flush;
  assign occ       = 3'(ob_cnt) + 3'(inflight) - 3'(pop);
  assign ren       = ram_cnt != '0 && occ < 3'd2 && !flush;
  assign RAM_WEN   = push;
  assign RAM_WADDR = wr_ptr;
  assign RAM_WD    = WR_DATA;
  assign RAM_REN   = ren;
  assign RAM_RADDR = rd_ptr;
  assign COUNT     = cnt;
  always_ff @(posedge PCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + ADDR_W'(push);
      rd_ptr   <= rd_ptr + ADDR_W'(ren);
      cnt      <= cnt + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
      ram_cnt  <= ram_cnt + (ADDR_W+1)'(push) - (ADDR_W+1)'(ren);
      inflight <= ren;
    end
  end
  coreabc_fifo_outbuf #(.DATA_W(DATA_W)) u_outbuf (
    .clk      (PCLK),
    .rst_n    (NSYSRESET),
    .flush    (flush),
    .inflight (inflight),
    .ram_rd   (RAM_RD),
    .rd_ready (RD_READY),
    .rd_valid (RD_VALID),
    .rd_data  (RD_DATA),
    .ob_cnt   (ob_cnt)
  );
endmodule

// File: tb/tb_coreabc_ram_fifo_ctrl.sv
// tb_coreabc_ram_fifo_ctrl: directed and scoreboard bench for coreabc_ram_fifo_ctrl with a 256x8 RAM model
module tb_coreabc_ram_fifo_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic wr_valid = 1'b0, rd_ready = 1'b0;
  logic [7:0] wr_data = '0;
  logic wr_ready, rd_valid, ram_wen, ram_ren;
  logic [7:0] rd_data, ram_waddr, ram_wd, ram_raddr, ram_rd;
  logic [8:0] count;
  logic [7:0] mem [256];
  int checks = 0, errors = 0, pops = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic [7:0] q [$];

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (ram_wen) mem[ram_waddr] <= ram_wd;
    if (ram_ren) ram_rd <= mem[ram_raddr];
  end

  coreabc_ram_fifo_ctrl dut (
    .PCLK      (clk),
    .NSYSRESET (rst_n),
`ifdef COREABC_FIFO_FLUSH_EN
    .FLUSH     (flush),
`endif
    .WR_VALID  (wr_valid),
    .WR_READY  (wr_ready),
    .WR_DATA   (wr_data),
    .RD_VALID  (rd_valid),
    .RD_READY  (rd_ready),
    .RD_DATA   (rd_data),
    .COUNT     (count),
    .RAM_WEN   (ram_wen),
    .RAM_WADDR (ram_waddr),
    .RAM_WD    (ram_wd),
    .RAM_REN   (ram_ren),
    .RAM_RADDR (ram_raddr),
    .RAM_RD    (ram_rd)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic wv, input logic [7:0] wd, input logic rr);
    @(posedge clk);
    #1;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    @(negedge clk);
  endtask

  // one cycle against the queue model: count, ready, stall stability and popped data
  task automatic mcycle(input logic wv, input logic [7:0] wd, input logic rr);
    logic exp_rdy;
    drive(wv, wd, rr);
    exp_rdy = q.size() < 256;
    chk("count", 32'(count), q.size());
    chk("wr_ready", 32'(wr_ready), 32'(exp_rdy));
    chk("phantom", 32'(rd_valid && q.size() == 0), 0);
    if (prev_stall) begin
      chk("stall_valid", 32'(rd_valid), 1);
      chk("stall_data", 32'(rd_data), 32'(prev_data));
    end
    prev_stall = rd_valid && !rr;
    prev_data  = rd_data;
    if (rd_valid && rr && q.size() > 0) begin
      chk("pop_data", 32'(rd_data), 32'(q.pop_front()));
      pops++;
    end
    if (wv && exp_rdy) q.push_back(wd);
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && q.size() > 0; k++) mcycle(1'b0, 8'h00, 1'b1);
    mcycle(1'b0, 8'h00, 1'b0);
    chk("drain_left", q.size(), 0);
    chk("drain_valid", 32'(rd_valid), 0);
  endtask

  typedef struct {
    logic wv; logic [7:0] wd; logic rr;
    logic ev; logic [7:0] ed; logic [8:0] ec; logic ew;
  } vec_t;
  vec_t tv[10];

  initial begin
    logic [7:0] last_wa, last_ra;
    logic wrap_w, wrap_r;
    tv[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 9'd0, 1'b1};
    tv[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 9'd1, 1'b1};
    tv[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 8'h11, 9'd2, 1'b1};
    tv[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 9'd3, 1'b1};
    tv[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 9'd3, 1'b1};
    tv[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 9'd3, 1'b1};
    tv[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 9'd2, 1'b1};
    tv[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 9'd1, 1'b1};
    tv[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h33, 9'd0, 1'b1};
    tv[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h33, 9'd0, 1'b1};

    // asynchronous reset in the middle of a stream
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'hA0 + i), 1'b0);
    @(posedge clk);
    #1 wr_valid = 1'b0;
    #2 chk("pre_reset_count", 32'(count), 5);
    chk("pre_reset_valid", 32'(rd_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_wr_ready", 32'(wr_ready), 1);
    chk("rst_data", 32'(rd_data), 0);
    chk("rst_ren", 32'(ram_ren), 0);
    chk("rst_waddr", 32'(ram_waddr), 0);
    chk("rst_raddr", 32'(ram_raddr), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // table: three pushes, hold under stall, then three pops
    for (int i = 0; i < 10; i++) begin
      drive(tv[i].wv, tv[i].wd, tv[i].rr);
      chk($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(tv[i].ev));
      chk($sformatf("vec%0d_data", i), 32'(rd_data), 32'(tv[i].ed));
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(tv[i].ec));
      chk($sformatf("vec%0d_ready", i), 32'(wr_ready), 32'(tv[i].ew));
    end

    // fill to 256, reject a 257th push, pop one while full
    prev_stall = 1'b0;
    for (int i = 0; i < 256; i++) mcycle(1'b1, 8'(i), 1'b0);
    mcycle(1'b1, 8'hAA, 1'b0);
    chk("full_wen", 32'(ram_wen), 0);
    chk("full_count", 32'(count), 256);
    mcycle(1'b1, 8'hAA, 1'b1);
    chk("full_pop_ready", 32'(wr_ready), 0);
    mcycle(1'b0, 8'h00, 1'b0);
    chk("after_pop_ready", 32'(wr_ready), 1);
    drain();

    // continuous streaming with pointer wrap
    pops = 0;
    wrap_w = 1'b0;
    wrap_r = 1'b0;
    last_wa = ram_waddr;
    last_ra = ram_raddr;
    for (int i = 0; i < 600; i++) begin
      mcycle(1'b1, 8'(i), 1'b1);
      if (i < 2) chk("stream_fill_valid", 32'(rd_valid), 0);
      if (i == 2) chk("stream_first_valid", 32'(rd_valid), 1);
      if (ram_wen) begin
        if (last_wa == 8'hFF && ram_waddr == 8'h00) wrap_w = 1'b1;
        last_wa = ram_waddr;
      end
      if (ram_ren) begin
        if (last_ra == 8'hFF && ram_raddr == 8'h00) wrap_r = 1'b1;
        last_ra = ram_raddr;
      end
    end
    chk("stream_pops", pops, 598);
    chk("wrap_waddr", 32'(wrap_w), 1);
    chk("wrap_raddr", 32'(wrap_r), 1);
    drain();

    // random push/pop against the scoreboard
    for (int i = 0; i < 10000; i++)
      mcycle(1'($urandom_range(0, 9) < 7), 8'($urandom), 1'($urandom_range(0, 1)));
    drain();

`ifdef COREABC_FIFO_FLUSH_EN
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'hC0 + i), 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    chk("fl_pre_data", 32'(rd_data), 32'hC0);
    chk("fl_pre_ren", 32'(ram_ren), 1);
    @(posedge clk);
    #1;
    wr_valid = 1'b1;
    wr_data  = 8'h77;
    rd_ready = 1'b0;
    flush    = 1'b1;
    @(negedge clk);
    chk("fl_count_before", 32'(count), 4);
    chk("fl_wr_ready", 32'(wr_ready), 0);
    chk("fl_wen", 32'(ram_wen), 0);
    chk("fl_ren", 32'(ram_ren), 0);
    @(posedge clk);
    #1;
    flush   = 1'b0;
    wr_data = 8'h5C;
    @(negedge clk);
    chk("fl_valid", 32'(rd_valid), 0);
    chk("fl_count", 32'(count), 0);
    chk("fl_waddr", 32'(ram_waddr), 0);
    drive(1'b0, 8'h00, 1'b0);
    chk("fl_stale", 32'(rd_valid), 0);
    drive(1'b0, 8'h00, 1'b0);
    chk("fl_new_valid", 32'(rd_valid), 1);
    chk("fl_new_data", 32'(rd_data), 32'h5C);
    chk("fl_new_count", 32'(count), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
